// File: rtl/out_bcd_converter_if.sv
// ----------------------------------------------------------------------------
// out_bcd_converter_if
//  Bundles the data path between the CPU 'out' register and the BCD display
//  converter.
//  Signals:
//   in     binary value from the CPU 'out' register  (master -> slave)
//   bcd    packed BCD, digit 0 (ones) in [3:0]        (slave -> master)
//   neg    sign of the displayed value                (slave -> master)
//   busy   conversion in progress                     (slave -> master)
//   valid  one-cycle pulse when bcd/neg update        (slave -> master)
//  Modports:
//   master  the producer/observer side (CPU side, testbench)
//   slave   the converter itself
// ----------------------------------------------------------------------------
interface out_bcd_converter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
);
    logic [DATA_WIDTH-1:0] in;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  busy;
    logic                  valid;

    modport master (
        output in,
        input  bcd,
        input  neg,
        input  busy,
        input  valid
    );

    modport slave (
        input  in,
        output bcd,
        output neg,
        output busy,
        output valid
    );
endinterface

// File: rtl/out_bcd_converter.sv
// ----------------------------------------------------------------------------
// out_bcd_converter
//  Watches the CPU 'out' register and converts every new value to packed BCD
//  for the 7-segment display driver. Conversion uses an iterative
//  shift-add-3 (double-dabble) engine that consumes one binary bit per clock.
//  A value change seen while a conversion is running is not lost: on return
//  to IDLE the input is compared with the last captured value again, so the
//  most recent value always ends up on the display (intermediate values may
//  be skipped).
//
//  Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   bus.in     binary input value (DATA_WIDTH bits)
//   bus.bcd    packed BCD result, digit 0 (ones) in [3:0]
//   bus.neg    sign of the displayed value (0 unless signed mode)
//   bus.busy   conversion in progress
//   bus.valid  one-cycle pulse when bcd/neg update
//
//  Parameters:
//   DATA_WIDTH  width of the binary input
//   DIGITS      BCD digits produced; 10^DIGITS must exceed 2^DATA_WIDTH
//
//  Build option:
//   OUT_BCD_SIGNED_EN  when defined, 'in' is two's complement; the magnitude
//                      is converted and the sign is reported on 'neg'.
//                      When undefined, 'in' is unsigned and 'neg' stays 0.
// ----------------------------------------------------------------------------
module out_bcd_converter #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    out_bcd_converter_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] last_reg;
    logic [DATA_WIDTH-1:0] sh_reg;
    logic [BCD_W-1:0]      work_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  sign_reg;
    logic [BCD_W-1:0]      bcd_reg;
    logic                  neg_reg;
    logic                  busy_reg;
    logic                  valid_reg;

    // Combinational helpers
    logic [BCD_W-1:0]      work_corr;
    logic [DATA_WIDTH-1:0] mag_next;
    logic                  sign_next;

    // ------------------------------------------------------------------
    // Add-3 correction: every digit that is 5 or more gets +3 before the
    // shift so that doubling it carries correctly into the next digit.
    // The sum stays inside the 4-bit digit (max 9+3 = 12).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_corr
            assign work_corr[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                        ? work_reg[4*gi +: 4] + 4'd3
                                        : work_reg[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sign / magnitude of the incoming value, evaluated at capture time.
    // In signed mode the negation wraps in DATA_WIDTH bits, so the most
    // negative value maps onto itself, which read unsigned is exactly its
    // magnitude (e.g. 0x8000 -> 32768).
    // ------------------------------------------------------------------
`ifdef OUT_BCD_SIGNED_EN
    assign sign_next = bus.in[DATA_WIDTH-1];
    assign mag_next  = sign_next ? (~bus.in + DATA_WIDTH'(1)) : bus.in;
`else
    assign sign_next = 1'b0;
    assign mag_next  = bus.in;
`endif

    // ------------------------------------------------------------------
    // Control FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= '0;
            sh_reg    <= '0;
            work_reg  <= '0;
            cnt_reg   <= '0;
            sign_reg  <= 1'b0;
            bcd_reg   <= '0;
            neg_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (bus.in != last_reg) begin
                        last_reg  <= bus.in;
                        sh_reg    <= mag_next;
                        sign_reg  <= sign_next;
                        work_reg  <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Binary bits leave sh from the top and enter work at bit 0.
                    {work_reg, sh_reg} <= {work_corr, sh_reg} << 1;
                    cnt_reg            <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    bcd_reg   <= work_reg;
                    neg_reg   <= sign_reg;
                    valid_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bcd   = bcd_reg;
    assign bus.neg   = neg_reg;
    assign bus.busy  = busy_reg;
    assign bus.valid = valid_reg;

endmodule

// File: tb/tb_out_bcd_converter.sv
// ----------------------------------------------------------------------------
// tb_out_bcd_converter
//  Self-checking bench for out_bcd_converter. A table of directed values with
//  hand-computed BCD results (unsigned and signed interpretations) is applied
//  in a loop; hand-written sequences cover idle-after-reset, input changes
//  while busy, reset mid-conversion and the single-conversion-per-value rule.
//  Build with +define+OUT_BCD_SIGNED_EN to check the signed variant.
// ----------------------------------------------------------------------------
module tb_out_bcd_converter;

    localparam int DW = 16;
    localparam int DG = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    out_bcd_converter_if #(.DATA_WIDTH(DW), .DIGITS(DG)) bus ();

    out_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] din;
        logic [19:0] bcd_u;   // expected when unsigned
        logic [19:0] bcd_s;   // expected when signed
        logic        neg_s;   // expected sign when signed
    } vec_t;

    vec_t vecs [10];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for the valid pulse, sampling 1 time unit after each rising edge.
    // Returns the number of edges consumed; ok=0 if the bound expired.
    task automatic wait_valid(output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [19:0] exp_bcd(input vec_t v);
`ifdef OUT_BCD_SIGNED_EN
        return v.bcd_s;
`else
        return v.bcd_u;
`endif
    endfunction

    function automatic logic exp_neg(input vec_t v);
`ifdef OUT_BCD_SIGNED_EN
        return v.neg_s;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        int  edges;
        bit  ok;
        int  busy_seen;
        int  valid_seen;

        vecs[0] = '{16'd1234,  20'h01234, 20'h01234, 1'b0};
        vecs[1] = '{16'hFFFF,  20'h65535, 20'h00001, 1'b1};
        vecs[2] = '{16'd0,     20'h00000, 20'h00000, 1'b0};
        vecs[3] = '{16'd9,     20'h00009, 20'h00009, 1'b0};
        vecs[4] = '{16'd10,    20'h00010, 20'h00010, 1'b0};
        vecs[5] = '{16'h8000,  20'h32768, 20'h32768, 1'b1};
        vecs[6] = '{16'd32767, 20'h32767, 20'h32767, 1'b0};
        vecs[7] = '{16'd100,   20'h00100, 20'h00100, 1'b0};
        vecs[8] = '{16'd1,     20'h00001, 20'h00001, 1'b0};
        vecs[9] = '{16'd59999, 20'h59999, 20'h05537, 1'b1};

        // ---- Reset with in == 0: outputs at reset values, no conversion ----
        bus.in = '0;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd",   32'(bus.bcd),   32'h0);
        chk("rst_neg",   32'(bus.neg),   32'h0);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        rst = 1'b0;
        busy_seen  = 0;
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1)  busy_seen++;
            if (bus.valid === 1'b1) valid_seen++;
        end
        chk("idle0_busy",  32'(busy_seen),  32'd0);
        chk("idle0_valid", 32'(valid_seen), 32'd0);
        chk("idle0_bcd",   32'(bus.bcd),    32'h0);
        $display("idle after reset: busy_seen=%0d valid_seen=%0d bcd=0x%05h", busy_seen, valid_seen, bus.bcd);

        // ---- Table-driven conversions ----
        for (int i = 0; i < 10; i++) begin
            bus.in = vecs[i].din;
            @(posedge clk);
            #1;
            chk("busy_rise", 32'(bus.busy), 32'h1);
            wait_valid(edges, ok);
            chk("latency", 32'(edges), 32'd17);
            chk("bcd",     32'(bus.bcd), 32'(exp_bcd(vecs[i])));
            chk("neg",     32'(bus.neg), 32'(exp_neg(vecs[i])));
            chk("busy_done", 32'(bus.busy), 32'h0);
            @(posedge clk);
            #1;
            chk("valid_pulse", 32'(bus.valid), 32'h0);
            $display("vec %0d: in=0x%04h bcd=0x%05h neg=%0b exp=0x%05h/%0b lat=%0d",
                     i, vecs[i].din, bus.bcd, bus.neg, exp_bcd(vecs[i]), exp_neg(vecs[i]), edges);
        end

        // ---- Held input: exactly one conversion ----
        busy_seen  = 0;
        valid_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1)  busy_seen++;
            if (bus.valid === 1'b1) valid_seen++;
        end
        chk("hold_busy",  32'(busy_seen),  32'd0);
        chk("hold_valid", 32'(valid_seen), 32'd0);
        $display("held input: busy_seen=%0d valid_seen=%0d", busy_seen, valid_seen);

        // ---- Changes while busy: 100 shown, 7 skipped, 42 shown ----
        bus.in = 16'd100;
        @(posedge clk);              // capture
        repeat (5) @(posedge clk);
        #1;
        bus.in = 16'd7;
        repeat (5) @(posedge clk);
        #1;
        bus.in = 16'd42;
        wait_valid(edges, ok);
        chk("skip_first", 32'(bus.bcd), 32'h00100);
        $display("busy change 1st: bcd=0x%05h", bus.bcd);
        wait_valid(edges, ok);
        chk("skip_second", 32'(bus.bcd), 32'h00042);
        chk("skip_latency", 32'(edges), 32'd18);
        $display("busy change 2nd: bcd=0x%05h lat=%0d", bus.bcd, edges);

        // ---- Reset mid-conversion ----
        bus.in = 16'd500;
        @(posedge clk);              // capture
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy",  32'(bus.busy),  32'h0);
        chk("abort_bcd",   32'(bus.bcd),   32'h0);
        chk("abort_valid", 32'(bus.valid), 32'h0);
        chk("abort_neg",   32'(bus.neg),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(edges, ok);
        chk("restart_bcd",     32'(bus.bcd), 32'h00500);
        chk("restart_latency", 32'(edges),   32'd18);
        $display("reset mid-conversion: restart bcd=0x%05h lat=%0d", bus.bcd, edges);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
